counter_enable_pacer: RTL
=========================

# counter_enable_pacer

Upstream feeder for `counter_with_strobe`. It accepts a raw, bursty event stream and queues the events in a pending count. It then issues single-cycle `enable` pulses no faster than the counter's `LATENCY` recovery rule allows. It also owns the counter's `reset_value` and applies period changes only in the cycle window the counter tolerates (strobe high, enable low).

## Interface
Parameters:
- `WIDTH`, 4: width of the period / `reset_value` bus; must match the downstream counter.
- `LATENCY`, 4: downstream counter latency; sets the minimum enable spacing.
- `PEND_WIDTH`, 4: width of the pending-event counter.
- `RESET_PERIOD`, 2: value driven on `reset_value_out` after reset; must be ≥2.

Ports:
- `clk`, in, 1: sole clock; all state changes on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `event_in`, in, 1: one event per high cycle.
- `period_in`, in, WIDTH: new period, sampled when `period_load`=1.
- `period_load`, in, 1: period update request.
- `strobe_in`, in, 1: strobe from the downstream counter.
- `ovf_clr`, in, 1: clears the sticky `overflow` flag.
- `enable_out`, out, 1: connects to the counter's `enable`.
- `reset_value_out`, out, WIDTH: connects to the counter's `reset_value`.
- `period_busy`, out, 1: a loaded period is waiting to be applied.
- `pending`, out, PEND_WIDTH: number of queued events not yet issued.
- `overflow`, out, 1: sticky flag; an event was dropped.

## Operation
- Reset values (`rst`=0): `enable_out`=0, `pending`=0, `overflow`=0, `period_busy`=0, `reset_value_out`=`RESET_PERIOD`, FSM=`S_GAP`, gap count=0, `primed`=0.
- Pending counter:
  - +1 on `event_in`.
  - −1 on the edge that registers `enable_out`=1.
  - Both in the same cycle: unchanged.
- FSM has two states:
  - `S_GAP`: the gap counter increments each cycle. When it reaches `LATENCY`, go to `S_READY`.
  - `S_READY`: when `pending`≠0, register `enable_out`=1 for exactly one cycle, clear the gap counter, set `primed`, and return to `S_GAP`.
  - In `S_READY` with `pending`=0, hold.
- `enable_out` is never high in two consecutive cycles.
- Period update:
  - `period_load`=1 latches `period_in` into a shadow register and sets `period_busy`.
  - Values <2 are clamped to 2.
  - A load while already busy overwrites the shadow; the last write wins.
- Period apply: `reset_value_out` takes the shadow value and `period_busy` clears on the edge after a cycle in which either:
  - `strobe_in`=1 and `enable_out`=0, or
  - `primed`=0 (no enable issued since reset).
- Apply and a new load in the same cycle: the old shadow is applied, and the new value stays pending with `period_busy`=1.
- `reset_value_out` is otherwise stable.
- Reset mid-operation: all state returns to reset values immediately, including queued events and any unapplied period.

## Timing
- `enable_out` is registered. Latency from `event_in` (with the FSM in `S_READY` and `pending`=0) to `enable_out` is 2 cycles: pending updates, then enable issues.
- Spacing: with `enable_out` high in cycle t, the next `enable_out` is no earlier than cycle t+`LATENCY`+2, so at least `LATENCY`+1 low cycles separate enables.
- After reset release, the first `enable_out` is no earlier than cycle `LATENCY`+1, counting the first edge with `rst`=1 as cycle 0.
- Sustained throughput is one enable per `LATENCY`+2 cycles. Bursts above this rate queue in `pending`.
- `period_busy` asserts the edge after `period_load` and falls on the apply edge.

## Configuration
- `PACER_OVERFLOW_EN` defined:
  - An event arriving with `pending` at all-ones (and no simultaneous issue) is dropped.
  - `pending` saturates, and `overflow` sets and holds until `ovf_clr`=1.
  - `ovf_clr` and a drop in the same cycle: `overflow` stays set.
- `PACER_OVERFLOW_EN` undefined:
  - `pending` wraps modulo 2^`PEND_WIDTH`.
  - `overflow` is tied 0 and `ovf_clr` is ignored.

## Test plan
- Reset spacing: `LATENCY`=4, one `event_in` pulse in cycle 0 after reset release -> `enable_out` high only in cycle 5, `pending` returns to 0.
- Burst: 3 consecutive `event_in` cycles with the FSM in `S_READY` -> `pending` peaks at 3, enables appear in cycles t, t+6, t+12, then `pending`=0.
- Simultaneous event and issue: `event_in`=1 in the cycle `enable_out` is registered with `pending`=1 -> `pending` remains 1, next enable follows `LATENCY`+2 cycles later.
- Period update:
  - After the first enable, `period_load` with `period_in`=9 -> `period_busy`=1 and `reset_value_out` unchanged until a cycle with `strobe_in`=1, `enable_out`=0.
  - Then `reset_value_out`=9 and `period_busy`=0.
  - `period_in`=1 applies as 2.
- Overflow (`PACER_OVERFLOW_EN`, `PEND_WIDTH`=4): 20 back-to-back events -> `pending` saturates at 15, `overflow`=1 and held until `ovf_clr`.
- Without the macro: same stimulus -> `pending` wraps, `overflow`=0.
- Async reset: assert `rst`=0 mid-burst with `pending`=5 -> outputs take reset values without a clock edge, and no `enable_out` for `LATENCY`+1 cycles after release.

Source files
------------

// File: rtl/counter_enable_pacer.sv
// Event pacer feeding counter_with_strobe: queues bursty events and spaces enable pulses.
// Optional build macro PACER_OVERFLOW_EN: saturating pending count with a sticky overflow flag.
module counter_enable_pacer #(
  parameter int WIDTH        = 4,
  parameter int LATENCY      = 4,
  parameter int PEND_WIDTH   = 4,
  parameter int RESET_PERIOD = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  event_in,
  input  logic [WIDTH-1:0]      period_in,
  input  logic                  period_load,
  input  logic                  strobe_in,
  input  logic                  ovf_clr,
  output logic                  enable_out,
  output logic [WIDTH-1:0]      reset_value_out,
  output logic                  period_busy,
  output logic [PEND_WIDTH-1:0] pending,
  output logic                  overflow
);

  localparam int GAP_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

  typedef enum logic {S_GAP = 1'b0, S_READY = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic                    enable_q, enable_d;
  logic                    primed_q, primed_d;
  logic [PEND_WIDTH-1:0]   pending_q, pending_d;
  logic [WIDTH-1:0]        shadow_q, shadow_d;
  logic [WIDTH-1:0]        rv_q, rv_d;
  logic                    busy_q, busy_d;
  logic                    apply_s;

  // The downstream counter misbehaves with a period below 2.
  function automatic logic [WIDTH-1:0] clamp_period(input logic [WIDTH-1:0] p);
    if (p < WIDTH'(2)) begin
      clamp_period = WIDTH'(2);
    end else begin
      clamp_period = p;
    end
  endfunction

  // Spacing FSM: count out the recovery gap, then issue one enable per queued event.
  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    enable_d = 1'b0;
    primed_d = primed_q;
    case (state_q)
      S_GAP: begin
        if (gap_q == GAP_W'(LATENCY)) begin
          state_d = S_READY;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      S_READY: begin
        if (pending_q != PEND_WIDTH'(0)) begin
          enable_d = 1'b1;
          gap_d    = GAP_W'(0);
          primed_d = 1'b1;
          state_d  = S_GAP;
        end else begin
          state_d = S_READY;
        end
      end
      default: begin
        state_d = S_GAP;
        gap_d   = GAP_W'(0);
      end
    endcase
  end

`ifdef PACER_OVERFLOW_EN
  logic drop_s;
  logic overflow_q, overflow_d;

  // Pending queue with saturation; a dropped event raises the sticky flag.
  always_comb begin
    pending_d = pending_q;
    drop_s    = 1'b0;
    if (event_in && !enable_d) begin
      if (&pending_q) begin
        drop_s = 1'b1;
      end else begin
        pending_d = pending_q + PEND_WIDTH'(1);
      end
    end else if (!event_in && enable_d) begin
      pending_d = pending_q - PEND_WIDTH'(1);
    end else begin
      pending_d = pending_q;
    end
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Sticky overflow register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;
`else
  // Pending queue wrapping modulo its width.
  always_comb begin
    pending_d = pending_q;
    if (event_in && !enable_d) begin
      pending_d = pending_q + PEND_WIDTH'(1);
    end else if (!event_in && enable_d) begin
      pending_d = pending_q - PEND_WIDTH'(1);
    end else begin
      pending_d = pending_q;
    end
  end

  // ovf_clr has no effect in this build.
  assign overflow = 1'b0 & ovf_clr;
`endif

  // Period shadow: apply only while the counter tolerates it, or before any enable.
  assign apply_s = busy_q && ((strobe_in && !enable_q) || !primed_q);

  always_comb begin
    shadow_d = shadow_q;
    busy_d   = busy_q;
    rv_d     = rv_q;
    if (apply_s) begin
      rv_d = shadow_q;
    end else begin
      rv_d = rv_q;
    end
    if (period_load) begin
      shadow_d = clamp_period(period_in);
      busy_d   = 1'b1;
    end else if (apply_s) begin
      busy_d = 1'b0;
    end else begin
      busy_d = busy_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_GAP;
      gap_q     <= GAP_W'(0);
      enable_q  <= 1'b0;
      primed_q  <= 1'b0;
      pending_q <= PEND_WIDTH'(0);
      shadow_q  <= WIDTH'(RESET_PERIOD);
      rv_q      <= WIDTH'(RESET_PERIOD);
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      enable_q  <= enable_d;
      primed_q  <= primed_d;
      pending_q <= pending_d;
      shadow_q  <= shadow_d;
      rv_q      <= rv_d;
      busy_q    <= busy_d;
    end
  end

  assign enable_out      = enable_q;
  assign reset_value_out = rv_q;
  assign period_busy     = busy_q;
  assign pending         = pending_q;

endmodule
